// File: rtl/frame_border_padder_pkg.sv
// Shared constants and helpers for the frame border padder.
package isp_pad_pkg;

  localparam logic [1:0] PAD_ZERO  = 2'd0;
  localparam logic [1:0] PAD_CONST = 2'd1;
  localparam logic [1:0] PAD_REPL  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TOP    = 3'd1,
    ST_ROWS   = 3'd2,
    ST_BOTTOM = 3'd3,
    ST_DONE   = 3'd4
  } pad_state_t;

  // Border width on each side for an odd KxK kernel.
  function automatic int unsigned border_w(input int unsigned kernel);
    return (kernel - 1) / 2;
  endfunction

endpackage

// File: rtl/frame_border_padder_line_buffer_ram.sv
// One line of pixel storage: simple dual-port RAM with a registered read port.
module line_buffer_ram #(
  parameter int unsigned DEPTH = 320,
  parameter int unsigned DW    = 24,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port and read port; the read data holds while re_i is low.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_border_padder.sv
// Streams a raster frame out with a kernel-derived border on all four sides.
module frame_border_padder
  import isp_pad_pkg::*;
#(
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned HEIGHT      = 240,
  parameter int unsigned KERNEL_SIZE = 7,
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned PIXEL_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    iMode,
  input  logic [CHANNELS*PIXEL_W-1:0]   iConst,
  input  logic                          sValid,
  output logic                          sReady,
  input  logic [CHANNELS*PIXEL_W-1:0]   sData,
  output logic                          mValid,
  input  logic                          mReady,
  output logic [CHANNELS*PIXEL_W-1:0]   mData,
  output logic                          mSol,
  output logic                          mEol,
  output logic                          mEof,
  output logic                          oDone
);

  localparam int unsigned B   = border_w(KERNEL_SIZE);
  localparam int unsigned DW  = CHANNELS * PIXEL_W;
  localparam int unsigned OW  = WIDTH + 2 * B;
  localparam int unsigned OH  = HEIGHT + 2 * B;
  localparam int unsigned XW  = $clog2(OW);
  localparam int unsigned YW  = $clog2(OH);
  localparam int unsigned IXW = $clog2(WIDTH);
  localparam int unsigned IYW = $clog2(HEIGHT);

  localparam logic [XW-1:0]  OX_LAST     = XW'(OW - 1);
  localparam logic [XW-1:0]  X_LEFT_END  = XW'(B);
  localparam logic [XW-1:0]  X_RIGHT_BEG = XW'(B + WIDTH);
  localparam logic [YW-1:0]  OY_LAST     = YW'(OH - 1);
  localparam logic [YW-1:0]  Y_TOP_LAST  = YW'(B - 1);
  localparam logic [YW-1:0]  Y_ROW_LAST  = YW'(B + HEIGHT - 1);
  localparam logic [IXW-1:0] IX_LAST     = IXW'(WIDTH - 1);
  localparam logic [IYW-1:0] IY_LAST     = IYW'(HEIGHT - 1);

  pad_state_t     state_q;
  logic [XW-1:0]  outx_q;
  logic [YW-1:0]  outy_q;
  logic           rsel_q;
  logic [IXW-1:0] inx_q;
  logic [IYW-1:0] iny_q;
  logic           wsel_q;
  logic [1:0]     full_q;
  logic           in_done_q;
  logic [1:0]     mode_q;
  logic [DW-1:0]  const_q;

  logic           s1_valid_q, s1_sol_q, s1_eol_q, s1_eof_q, s1_rel_q, s1_border_q, s1_buf_q;
  logic           mvalid_q, msol_q, meol_q, meof_q, mrel_q, mbuf_q, odone_q;
  logic [DW-1:0]  mdata_q;

  logic           en, out_acc, s_acc, row0_done, can_issue, issue;
  logic           x_end, y_end, border;
  logic [XW-1:0]  xoff;
  logic [IXW-1:0] rd_addr;
  logic           rel_now;
  logic [DW-1:0]  rdata0, rdata1, ram_pix, pad_pix, pix_d;

  // Handshake, issue decision, clamped read address and border mux.
  always_comb begin
    sReady    = !reset && !in_done_q && !full_q[wsel_q];
    s_acc     = sValid && sReady;
    row0_done = s_acc && (inx_q == IX_LAST) && (iny_q == '0);
    en        = !mvalid_q || mReady;
    out_acc   = mvalid_q && mReady;
    rel_now   = out_acc && mrel_q;
    x_end     = (outx_q == OX_LAST);
    y_end     = (outy_q == OY_LAST);
    can_issue = 1'b0;
    case (state_q)
      ST_TOP:    can_issue = 1'b1;
      ST_ROWS:   can_issue = full_q[rsel_q];
      ST_BOTTOM: can_issue = (outy_q != '0);
      default:   can_issue = 1'b0;
    endcase
    issue   = en && can_issue;
    xoff    = outx_q - X_LEFT_END;
    rd_addr = IXW'(xoff);
    if (outx_q < X_LEFT_END)        rd_addr = '0;
    else if (outx_q >= X_RIGHT_BEG) rd_addr = IX_LAST;
    border  = (outx_q < X_LEFT_END) || (outx_q >= X_RIGHT_BEG) || (state_q != ST_ROWS);
    ram_pix = s1_buf_q ? rdata1 : rdata0;
    pad_pix = (mode_q == PAD_CONST) ? const_q : '0;
    pix_d   = ((mode_q == PAD_REPL) || !s1_border_q) ? ram_pix : pad_pix;
  end

  line_buffer_ram #(.DEPTH(WIDTH), .DW(DW), .AW(IXW)) u_buf0 (
    .clk     (clk),
    .we_i    (s_acc && !wsel_q),
    .waddr_i (inx_q),
    .wdata_i (sData),
    .re_i    (issue),
    .raddr_i (rd_addr),
    .rdata_o (rdata0)
  );

  line_buffer_ram #(.DEPTH(WIDTH), .DW(DW), .AW(IXW)) u_buf1 (
    .clk     (clk),
    .we_i    (s_acc && wsel_q),
    .waddr_i (inx_q),
    .wdata_i (sData),
    .re_i    (issue),
    .raddr_i (rd_addr),
    .rdata_o (rdata1)
  );

  // Input side: write counters, buffer ownership and per-frame mode capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      inx_q     <= '0;
      iny_q     <= '0;
      wsel_q    <= 1'b0;
      full_q    <= '0;
      in_done_q <= 1'b0;
      mode_q    <= PAD_ZERO;
      const_q   <= '0;
    end else if (state_q == ST_DONE) begin
      full_q    <= '0;
      wsel_q    <= 1'b0;
      in_done_q <= 1'b0;
    end else begin
      // A buffer being released can never be the write target this cycle,
      // because sReady is low whenever the write buffer is still owned.
      if (rel_now) full_q[mbuf_q] <= 1'b0;
      if (s_acc) begin
        if (inx_q == '0 && iny_q == '0) begin
          mode_q  <= iMode;
          const_q <= iConst;
        end
        if (inx_q == IX_LAST) begin
          inx_q          <= '0;
          full_q[wsel_q] <= 1'b1;
          wsel_q         <= ~wsel_q;
          if (iny_q == IY_LAST) begin
            iny_q     <= '0;
            in_done_q <= 1'b1;
          end else begin
            iny_q <= iny_q + 1'b1;
          end
        end else begin
          inx_q <= inx_q + 1'b1;
        end
      end
    end
  end

  // Output FSM, output counters and the two-stage (RAM read, output register) pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      outx_q      <= '0;
      outy_q      <= '0;
      rsel_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sol_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      s1_rel_q    <= 1'b0;
      s1_border_q <= 1'b0;
      s1_buf_q    <= 1'b0;
      mvalid_q    <= 1'b0;
      msol_q      <= 1'b0;
      meol_q      <= 1'b0;
      meof_q      <= 1'b0;
      mrel_q      <= 1'b0;
      mbuf_q      <= 1'b0;
      mdata_q     <= '0;
      odone_q     <= 1'b0;
    end else begin
      odone_q <= out_acc && meof_q;
      case (state_q)
        ST_IDLE: if (row0_done) state_q <= ST_TOP;
        ST_TOP, ST_ROWS, ST_BOTTOM: begin
          if (issue) begin
            outx_q <= x_end ? '0 : outx_q + 1'b1;
            if (x_end) outy_q <= y_end ? '0 : outy_q + 1'b1;
            if (x_end && state_q == ST_TOP && outy_q == Y_TOP_LAST) state_q <= ST_ROWS;
            if (x_end && state_q == ST_ROWS) begin
              if (outy_q == Y_ROW_LAST) state_q <= ST_BOTTOM;
              else                      rsel_q  <= ~rsel_q;
            end
          end
          if (state_q == ST_BOTTOM && out_acc && meof_q) state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          rsel_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (en) begin
        s1_valid_q  <= can_issue;
        s1_sol_q    <= can_issue && (outx_q == '0);
        s1_eol_q    <= can_issue && x_end;
        s1_eof_q    <= can_issue && x_end && y_end;
        // Interior rows free their buffer once their last beat leaves; the
        // final row stays owned so the bottom border can replicate it.
        s1_rel_q    <= can_issue && (state_q == ST_ROWS) && x_end && (outy_q != Y_ROW_LAST);
        s1_border_q <= border;
        s1_buf_q    <= rsel_q;
        mvalid_q    <= s1_valid_q;
        msol_q      <= s1_sol_q;
        meol_q      <= s1_eol_q;
        meof_q      <= s1_eof_q;
        mrel_q      <= s1_rel_q;
        mbuf_q      <= s1_buf_q;
        if (s1_valid_q) mdata_q <= pix_d;
      end
    end
  end

  assign mValid = mvalid_q;
  assign mData  = mdata_q;
  assign mSol   = msol_q;
  assign mEol   = meol_q;
  assign mEof   = meof_q;
  assign oDone  = odone_q;

endmodule
